// File: rtl/i2s_rx_deser.sv
// I2S / DSP serial receive deserialiser: frame-start detection, word assembly
// of 1..32 bits for up to 8 slots, and a small registered output FIFO.
module i2s_rx_deser #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic        cfg_dsp_en_i,
  input  logic        cfg_dsp_mode_i,
  input  logic [4:0]  cfg_word_size_i,
  input  logic [2:0]  cfg_word_num_i,
  input  logic        cfg_lsb_first_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [31:0] data_o,
  output logic [2:0]  data_word_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        overflow_o,
  output logic        sync_err_o,
  output logic        busy_o
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, WAIT_FS, ARM, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic       ws_q;
  logic [4:0] bitcnt, bitcnt_nxt;
  logic [2:0] wordcnt, wordcnt_nxt;

  logic       dsp_en_q, dsp_mode_q, lsb_first_q;
  logic [4:0] word_size_q;
  logic [2:0] word_num_q;

  logic       fs, start, sample, word_done, sync_set, cfg_load;
  logic [4:0] bit_idx;
  logic [2:0] word_idx;

  logic [DATA_W-1:0] shreg_p0;
  logic [2:0]        widx_p0;
  logic              vld_p0;

  logic [DATA_W+2:0] mem_p1 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, full, wr_en, ovf_set;
  logic              overflow_q, sync_err_q;

  // Word assembly: the first bit of a word starts from a cleared register so
  // unused MSBs stay zero in both bit orders.
  function automatic logic [DATA_W-1:0] assemble(input logic [DATA_W-1:0] cur,
                                                 input logic              sd,
                                                 input logic [4:0]        idx,
                                                 input logic              lsb_first);
    logic [DATA_W-1:0] base;
    base = (idx == 5'd0) ? '0 : cur;
    if (lsb_first) base[idx] = sd;
    else           base = {base[DATA_W-2:0], sd};
    return base;
  endfunction

  assign fs = dsp_en_q ? (!ws_q && ws_i) : (ws_q && !ws_i);

  always_comb begin
    state_nxt   = state;
    bitcnt_nxt  = bitcnt;
    wordcnt_nxt = wordcnt;
    start       = 1'b0;
    sample      = 1'b0;
    word_done   = 1'b0;
    sync_set    = 1'b0;
    cfg_load    = 1'b0;
    bit_idx     = bitcnt;
    word_idx    = wordcnt;
    if (!cfg_en_i) begin
      state_nxt   = IDLE;
      bitcnt_nxt  = '0;
      wordcnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_FS;
          cfg_load  = 1'b1;
        end
        WAIT_FS, DONE: start = fs;
        ARM, SHIFT: begin
          if (fs) begin
            start    = 1'b1;
            sync_set = 1'b1;
          end else begin
            sample = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // A frame start (normal or mid-frame) restarts at word 0, bit 0.
      if (start) begin
        bit_idx     = '0;
        word_idx    = '0;
        bitcnt_nxt  = '0;
        wordcnt_nxt = '0;
        if (dsp_en_q && dsp_mode_q) sample = 1'b1;
        else                        state_nxt = ARM;
      end
      if (sample) begin
        state_nxt = SHIFT;
        if (bit_idx == word_size_q) begin
          word_done  = 1'b1;
          bitcnt_nxt = '0;
          if (word_idx == word_num_q) begin
            state_nxt   = DONE;
            wordcnt_nxt = '0;
          end else begin
            wordcnt_nxt = word_idx + 3'd1;
          end
        end else begin
          bitcnt_nxt = bit_idx + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      ws_q        <= 1'b0;
      bitcnt      <= '0;
      wordcnt     <= '0;
      dsp_en_q    <= 1'b0;
      dsp_mode_q  <= 1'b0;
      lsb_first_q <= 1'b0;
      word_size_q <= '0;
      word_num_q  <= '0;
      vld_p0      <= 1'b0;
    end else begin
      state   <= state_nxt;
      ws_q    <= ws_i;
      bitcnt  <= bitcnt_nxt;
      wordcnt <= wordcnt_nxt;
      vld_p0  <= word_done;
      if (cfg_load) begin
        dsp_en_q    <= cfg_dsp_en_i;
        dsp_mode_q  <= cfg_dsp_mode_i;
        lsb_first_q <= cfg_lsb_first_i;
        word_size_q <= cfg_word_size_i;
        word_num_q  <= cfg_word_num_i;
      end
    end
  end

  // Stage p0: shift register and slot index of the word being assembled
  always_ff @(posedge sck_i) begin
    if (sample)    shreg_p0 <= assemble(shreg_p0, sd_i, bit_idx, lsb_first_q);
    if (word_done) widx_p0  <= word_idx;
  end

  // Stage p1: output FIFO, written one edge after the last bit of a word
  assign push    = vld_p0 && cfg_en_i;
  assign pop     = data_ready_i && (count != '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (!cfg_en_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count + CNT_W'(wr_en) - CNT_W'(pop);
      overflow_q <= overflow_q | ovf_set;
      sync_err_q <= sync_err_q | sync_set;
    end
  end

  always_ff @(posedge sck_i) begin
    if (wr_en) mem_p1[wr_ptr] <= {widx_p0, shreg_p0};
  end

  assign data_valid_o = (count != '0);
  assign data_o       = data_valid_o ? mem_p1[rd_ptr][DATA_W-1:0] : '0;
  assign data_word_o  = data_valid_o ? mem_p1[rd_ptr][DATA_W+2:DATA_W] : '0;
  assign overflow_o   = overflow_q;
  assign sync_err_o   = sync_err_q;
  assign busy_o       = (state != IDLE);

endmodule
